// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared CPU bus types used by the two-port bus arbiter.
// Holds the arbiter FSM state encoding and the port identifiers.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arbiter_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arbiter_port_t;

    localparam int BUS_WIDTH = 32;

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// bus_arbiter_watchdog: counts grant cycles without bus ready and flags expiry
// in the cycle the count reaches TIMEOUT-1; TIMEOUT = 0 never expires.
module bus_arbiter_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam logic        LP_ENABLED = (TIMEOUT > 0);
    localparam logic [31:0] LP_LAST    = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [31:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Expiry is only meaningful in a counting cycle, so a ready in that cycle wins.
    assign o_expired = LP_ENABLED && i_count_en && (r_count == LP_LAST);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one request/ready bus between CPU instruction (A) and data (B) ports.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise port B always wins ties.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pa_request,
    input  logic        i_pa_rw,
    input  logic [31:0] i_pa_address,
    input  logic [31:0] i_pa_wdata,
    output logic        o_pa_ready,
    output logic [31:0] o_pa_rdata,
    input  logic        i_pb_request,
    input  logic        i_pb_rw,
    input  logic [31:0] i_pb_address,
    input  logic [31:0] i_pb_wdata,
    output logic        o_pb_ready,
    output logic [31:0] o_pb_rdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_fault,
    output logic [31:0] o_contention
);

    arbiter_state_t r_state;
    arbiter_state_t w_next_state;
    arbiter_port_t  w_tie_winner;
    logic [31:0]    r_contention;
    logic           r_fault;
    logic           w_in_grant;
    logic           w_both_request;
    logic           w_expired;

    assign w_in_grant     = (r_state == GRANT_A) || (r_state == GRANT_B);
    assign w_both_request = i_pa_request && i_pb_request;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    arbiter_port_t r_last_grant;

    assign w_tie_winner = (r_last_grant == PORT_A) ? PORT_B : PORT_A;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant <= PORT_A;
        end else if (r_state == IDLE && w_next_state == GRANT_A) begin
            r_last_grant <= PORT_A;
        end else if (r_state == IDLE && w_next_state == GRANT_B) begin
            r_last_grant <= PORT_B;
        end
    end
`else
    assign w_tie_winner = PORT_B;
`endif

    bus_arbiter_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (r_state == IDLE),
        .i_count_en (w_in_grant && !i_bus_ready),
        .o_expired  (w_expired)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_contention <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_both_request) begin
                r_contention <= r_contention + 32'd1;
            end
            if (w_expired) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Requests are sampled only in IDLE, which guarantees the bubble cycle between grants.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_both_request) begin
                    w_next_state = (w_tie_winner == PORT_A) ? GRANT_A : GRANT_B;
                end else if (i_pa_request) begin
                    w_next_state = GRANT_A;
                end else if (i_pb_request) begin
                    w_next_state = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (i_bus_ready || w_expired) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        o_pa_ready    = 1'b0;
        o_pb_ready    = 1'b0;
        o_pa_rdata    = '0;
        o_pb_rdata    = '0;
        case (r_state)
            GRANT_A: begin
                o_bus_request = i_pa_request;
                o_bus_rw      = i_pa_rw;
                o_bus_address = i_pa_address;
                o_bus_wdata   = i_pa_wdata;
                o_pa_ready    = i_bus_ready || w_expired;
                if (i_bus_ready) begin
                    o_pa_rdata = i_bus_rdata;
                end
            end
            GRANT_B: begin
                o_bus_request = i_pb_request;
                o_bus_rw      = i_pb_rw;
                o_bus_address = i_pb_address;
                o_bus_wdata   = i_pb_wdata;
                o_pb_ready    = i_bus_ready || w_expired;
                if (i_bus_ready) begin
                    o_pb_rdata = i_bus_rdata;
                end
            end
            default: ;
        endcase
    end

    assign o_fault      = r_fault;
    assign o_contention = r_contention;

endmodule
